stream_serializer: RTL
======================

STREAM_SERIALIZER -- requirements
Module: stream_serializer

Interface
REQ-001 The block SHALL have one parameter: FIFO_DEPTH, default 2, the number of 96-bit words buffered ahead of serialization.
REQ-002 Port aclk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 Port aresetn, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port data_in, input, 96 bits: concatenated lane word; lane k occupies bits [8k+7:8k].
REQ-005 Port data_strobe, input, 1 bit: data_in is a new word this cycle.
REQ-006 Port M_AXIS_TDATA, output, 32 bits: serialized beat.
REQ-007 Port M_AXIS_TVALID, output, 1 bit: the beat is valid.
REQ-008 Port M_AXIS_TREADY, input, 1 bit: downstream accepts the beat.
REQ-009 Port M_AXIS_TLAST, output, 1 bit: high on the final beat of a word.
REQ-010 Port cnt_clear, input, 1 bit: synchronous clear of overflow_count.
REQ-011 Port overflow_count, output, 16 bits: number of dropped words, saturating.
REQ-012 Port fifo_level, output, clog2(FIFO_DEPTH+1) bits: current word occupancy.

Function
REQ-013 Each word SHALL be emitted as 3 beats, lowest bits first: beat0 = [31:0], beat1 = [63:32], beat2 = [95:64].
REQ-014 A beat SHALL transfer only on a cycle where TVALID and TREADY are both high.
REQ-015 Once TVALID is asserted, TDATA, TLAST and TVALID SHALL hold stable until the beat transfers.
REQ-016 The beat sequencer SHALL be a state machine with states BEAT0, BEAT1 and BEAT2.
- Transitions: BEAT0 -> BEAT1 -> BEAT2 -> BEAT0, advancing only on a transfer.
- TLAST is high only in BEAT2.
REQ-017 TVALID SHALL equal (fifo_level != 0).
REQ-018 TDATA SHALL be the slice of the FIFO head word selected by the current state.
REQ-019 The head word SHALL be popped on the BEAT2 transfer; the state returns to BEAT0 on the same edge.
REQ-020 A strobe at cycle N into an empty FIFO SHALL produce TVALID high at cycle N+1, carrying beat0 of that word.
REQ-021 A strobe with the FIFO not full SHALL write data_in at the tail and increment fifo_level.
REQ-022 A strobe while full and a BEAT2 transfer in the same cycle SHALL be accepted; fifo_level is unchanged.
REQ-023 A strobe while full with no pop SHALL drop the word and increment overflow_count, saturating at 0xFFFF.
- The FIFO and the sequencer are not disturbed.
REQ-024 cnt_clear SHALL force overflow_count to 0; if it coincides with an overflow, the clear wins.
REQ-025 Sustained throughput SHALL be one beat per cycle with TREADY held high, including across word boundaries (no bubble).
REQ-026 Write and read pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-027 While aresetn is low, the block SHALL hold:
- TVALID = 0, TLAST = 0, TDATA = 0
- state = BEAT0, fifo_level = 0, pointers = 0, overflow_count = 0
REQ-028 Reset asserted mid-word SHALL discard all buffered and partially sent words.
REQ-029 The first strobe after reset deassertion SHALL start a fresh word at BEAT0.
REQ-030 FIFO storage contents SHALL NOT require reset.

Structure
REQ-031 A shared package stream_pkg SHALL hold:
- constants LANE_W = 8, NUM_LANES = 12, WORD_W = 96, BEAT_W = 32, BEATS_PER_WORD = 3
- typedef beat_state_t for BEAT0 / BEAT1 / BEAT2
REQ-032 The word FIFO SHALL be one sub-module, word_fifo, providing push, pop, full, empty and level.
- The beat sequencer and the overflow counter reside in the top level.

Verification
REQ-033 Single word: strobe with data_in = 0x0B0A09080706050403020100 and TREADY = 1.
- Response: beats 0x03020100, 0x07060504, 0x0B0A0908 on consecutive cycles.
- TLAST high only on the third beat; first TVALID one cycle after the strobe.
REQ-034 Backpressure: TREADY low for 5 cycles during beat1.
- Response: TDATA holds 0x07060504 with TVALID high throughout, then the sequence completes.
REQ-035 Overflow: TREADY = 0, strobes on 4 consecutive cycles.
- Response: fifo_level = 2, overflow_count = 2.
- After TREADY = 1, exactly 6 beats carrying words 1 and 2.
REQ-036 Simultaneous push/pop: FIFO full, strobe on the BEAT2 transfer cycle.
- Response: word accepted, fifo_level stays 2, overflow_count unchanged.
REQ-037 Reset mid-word: assert aresetn low during beat1 for 2 cycles.
- Response: TVALID = 0 and fifo_level = 0; the next strobe emits its beat0 first.
REQ-038 Saturation and clear: preload overflow_count to 0xFFFE, then force 3 overflows.
- Response: reads 0xFFFF; after cnt_clear it reads 0.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared definitions for the stream serializer slice.
// Holds the lane/word/beat geometry, the beat sequencer state type and the
// helper that picks one beat out of a buffered word.
package stream_pkg;

    localparam int LANE_W         = 8;
    localparam int NUM_LANES      = 12;
    localparam int WORD_W         = 96;
    localparam int BEAT_W         = 32;
    localparam int BEATS_PER_WORD = 3;

    typedef enum logic [1:0] {
        BEAT0 = 2'd0,
        BEAT1 = 2'd1,
        BEAT2 = 2'd2
    } beat_state_t;

    // Lowest bits go out first: BEAT0 carries [31:0], BEAT2 carries [95:64].
    function automatic logic [BEAT_W-1:0] beat_slice(input logic [WORD_W-1:0] word,
                                                     input beat_state_t       st);
        logic [BEAT_W-1:0] slice_v;
        case (st)
            BEAT0:   slice_v = word[31:0];
            BEAT1:   slice_v = word[63:32];
            BEAT2:   slice_v = word[95:64];
            default: slice_v = {BEAT_W{1'b0}};
        endcase
        return slice_v;
    endfunction

endpackage

// File: rtl/word_fifo.sv
// Word FIFO holding whole 96-bit words ahead of serialization.
// Ports:
//   clk, rst_n    - clock and asynchronous active-low reset
//   push, wdata   - write a word at the tail (accepted when not full, or when
//                   a pop happens on the same edge)
//   pop           - remove the head word
//   rdata         - current head word (combinational view of storage)
//   full, empty   - occupancy flags
//   level         - current number of buffered words
module word_fifo
    import stream_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int LVL_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [LVL_W-1:0]  level
);

    logic [WORD_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [LVL_W-1:0]  level_r;
    logic              full_s;
    logic              empty_s;
    logic              do_push_s;
    logic              do_pop_s;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt_v;
        if (ptr == PTR_W'(DEPTH - 1)) begin
            nxt_v = {PTR_W{1'b0}};
        end else begin
            nxt_v = ptr + PTR_W'(1);
        end
        return nxt_v;
    endfunction

    assign full_s  = (level_r == LVL_W'(DEPTH));
    assign empty_s = (level_r == LVL_W'(0));

    // When full, a push is only taken alongside a pop; the write then lands in
    // the slot the head is vacating on that same edge.
    assign do_push_s = push && (!full_s || pop);
    assign do_pop_s  = pop && !empty_s;

    assign rdata = mem_r[rd_ptr_r];
    assign full  = full_s;
    assign empty = empty_s;
    assign level = level_r;

    // Word storage: data only, never reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= next_ptr(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/stream_serializer.sv
// Serializes buffered 96-bit lane words into three 32-bit AXI-Stream beats.
// Ports:
//   aclk, aresetn        - clock and asynchronous active-low reset
//   data_in, data_strobe - incoming word and its qualifier
//   M_AXIS_TDATA/TVALID/TREADY/TLAST - outgoing beat stream, TLAST on beat 2
//   cnt_clear            - synchronous clear of overflow_count
//   overflow_count       - saturating count of words dropped while full
//   fifo_level           - number of words currently buffered
module stream_serializer
    import stream_pkg::*;
#(
    parameter  int FIFO_DEPTH = 2,
    localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [WORD_W-1:0] data_in,
    input  logic              data_strobe,
    output logic [BEAT_W-1:0] M_AXIS_TDATA,
    output logic              M_AXIS_TVALID,
    input  logic              M_AXIS_TREADY,
    output logic              M_AXIS_TLAST,
    input  logic              cnt_clear,
    output logic [15:0]       overflow_count,
    output logic [LVL_W-1:0]  fifo_level
);

    beat_state_t       state_r;
    beat_state_t       state_next_s;
    logic [WORD_W-1:0] head_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [LVL_W-1:0]  fifo_level_s;
    logic              valid_s;
    logic              transfer_s;
    logic              pop_s;
    logic              overflow_s;
    logic [15:0]       overflow_count_r;

    assign valid_s    = !fifo_empty_s;
    assign transfer_s = valid_s && M_AXIS_TREADY;
    assign pop_s      = transfer_s && (state_r == BEAT2);
    // A pop on the same edge frees a slot, so only a strobe that meets a full
    // FIFO with no pop is lost.
    assign overflow_s = data_strobe && fifo_full_s && !pop_s;

    word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_word_fifo (
        .clk   (aclk),
        .rst_n (aresetn),
        .push  (data_strobe),
        .pop   (pop_s),
        .wdata (data_in),
        .rdata (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (fifo_level_s)
    );

    // Outputs are decoded from registered state only; TDATA is forced to zero
    // while idle so unreset storage never shows on the bus.
    assign M_AXIS_TVALID  = valid_s;
    assign M_AXIS_TDATA   = valid_s ? beat_slice(head_s, state_r) : {BEAT_W{1'b0}};
    assign M_AXIS_TLAST   = valid_s && (state_r == BEAT2);
    assign fifo_level     = fifo_level_s;
    assign overflow_count = overflow_count_r;

    // Beat sequencer state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r <= BEAT0;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Beat sequencer next state: advance only on a completed transfer.
    always_comb begin
        state_next_s = state_r;
        if (transfer_s) begin
            case (state_r)
                BEAT0:   state_next_s = BEAT1;
                BEAT1:   state_next_s = BEAT2;
                BEAT2:   state_next_s = BEAT0;
                default: state_next_s = BEAT0;
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // Saturating dropped-word counter; clear takes priority over a drop.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            overflow_count_r <= 16'h0000;
        end else if (cnt_clear) begin
            overflow_count_r <= 16'h0000;
        end else if (overflow_s && (overflow_count_r != 16'hFFFF)) begin
            overflow_count_r <= overflow_count_r + 16'h0001;
        end else begin
            overflow_count_r <= overflow_count_r;
        end
    end

endmodule
